// File: rtl/fetch_pkg.sv
// Shared constants for the fetch sequencer: RV32 base opcodes, instruction-format
// one-hot bit positions and the sequencer state encoding.
package fetch_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int FMT_R = 0;
    localparam int FMT_I = 1;
    localparam int FMT_S = 2;
    localparam int FMT_B = 3;
    localparam int FMT_U = 4;
    localparam int FMT_J = 5;
    localparam int FMT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_fmt_decode.sv
// Opcode -> one-hot instruction format classifier (R/I/S/B/U/J), purely combinational.
// Unrecognised opcodes, including any with bits [1:0] != 2'b11, give format 0 and illegal.
module fetch_fmt_decode
    import fetch_pkg::*;
(
    input  logic [6:0]       i_opcode,
    output logic [FMT_W-1:0] o_format,
    output logic             o_illegal
);

    always_comb begin
        o_format  = '0;
        o_illegal = 1'b0;
        case (i_opcode)
            OPC_OP:                                   o_format[FMT_R] = 1'b1;
            OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: o_format[FMT_I] = 1'b1;
            OPC_STORE:                                o_format[FMT_S] = 1'b1;
            OPC_BRANCH:                               o_format[FMT_B] = 1'b1;
            OPC_LUI, OPC_AUIPC:                       o_format[FMT_U] = 1'b1;
            OPC_JAL:                                  o_format[FMT_J] = 1'b1;
            default:                                  o_illegal       = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_seq.sv
// Single-outstanding instruction fetch sequencer with redirect/squash handling.
// Define FETCH_PERF_EN to build the fetch and squash performance counters.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_addr,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic [5:0]  o_format,
    output logic        o_illegal,
    output logic [31:0] o_fetch_count,
    output logic [31:0] o_squash_count
);

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic        discard, discard_nx;
    logic        load;
    logic [31:0] inst_buf;
    logic [31:0] inst_pc_buf;
    logic [5:0]  fmt;
    logic        ill;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            pc      <= RESET_ADDR;
            discard <= 1'b0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            discard <= discard_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        discard_nx = discard;
        load       = 1'b0;
        case (state)
            S_IDLE: state_nx = S_REQ;
            S_REQ: begin
                if (i_imem_gnt) begin
                    state_nx = S_WAIT;
                    // the granted request is for the old pc, so its reply must be dropped
                    if (i_redirect) discard_nx = 1'b1;
                end
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    if (discard || i_redirect) begin
                        discard_nx = 1'b0;
                        state_nx   = S_REQ;
                    end else begin
                        load     = 1'b1;
                        pc_nx    = pc + 32'd4;
                        state_nx = S_HOLD;
                    end
                end else if (i_redirect) begin
                    discard_nx = 1'b1;
                end
            end
            S_HOLD: begin
                if (i_inst_ready || i_redirect) state_nx = S_REQ;
            end
            default: state_nx = S_IDLE;
        endcase
        // last redirect wins; it overrides any pc+4 from this cycle
        if (i_redirect) pc_nx = i_redirect_addr & ~32'h3;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inst_buf    <= '0;
            inst_pc_buf <= RESET_ADDR;
        end else if (load) begin
            inst_buf    <= i_imem_rdata;
            inst_pc_buf <= pc;
        end
    end

    fetch_fmt_decode u_fmt (
        .i_opcode  (inst_buf[6:0]),
        .o_format  (fmt),
        .o_illegal (ill)
    );

    assign o_imem_req   = (state == S_REQ);
    assign o_imem_addr  = pc;
    assign o_inst_valid = (state == S_HOLD);
    assign o_inst       = inst_buf;
    assign o_inst_pc    = inst_pc_buf;
    assign o_format     = fmt;
    assign o_illegal    = ill & o_inst_valid;

`ifdef FETCH_PERF_EN
    logic        fetch_evt;
    logic        squash_evt;
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;

    assign fetch_evt  = (state == S_HOLD) && i_inst_ready && !i_redirect;
    assign squash_evt = ((state == S_HOLD) && i_redirect) ||
                        ((state == S_WAIT) && i_imem_rvalid && (discard || i_redirect));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (fetch_evt)  fetch_cnt  <= fetch_cnt + 32'd1;
            if (squash_evt) squash_cnt <= squash_cnt + 32'd1;
        end
    end

    assign o_fetch_count  = fetch_cnt;
    assign o_squash_count = squash_cnt;
`else
    assign o_fetch_count  = 32'd0;
    assign o_squash_count = 32'd0;
`endif

endmodule
